// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter
//   Write-port controller for the 32x32 register bank. After every reset it
//   optionally sweeps CLEAR_VALUE into x1..x31, then arbitrates the EX and MEM
//   writeback requesters round-robin onto the single registered write port.
//   Writes to x0 are accepted but never reach the bank.
//
// Parameters
//   CLEAR_EN     1 = run the clear sweep after reset, 0 = start in RUN
//   CLEAR_VALUE  data written to x1..x31 during the sweep
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   EX_VALID   in   EX writeback request
//   EX_ADDR    in   EX destination register
//   EX_DATA    in   EX writeback data
//   EX_READY   out  EX request accepted this cycle (combinational)
//   MEM_VALID  in   MEM writeback request
//   MEM_ADDR   in   MEM destination register
//   MEM_DATA   in   MEM writeback data
//   MEM_READY  out  MEM request accepted this cycle (combinational)
//   DIR_WR     out  bank write address (registered)
//   DI         out  bank write data (registered)
//   REG_WR     out  bank write enable (registered)
//   CLR_DONE   out  clear sweep finished, held until next reset
//   CONFLICT   out  both requesters were valid in RUN last cycle
module regbank_wr_arbiter #(
    parameter bit          CLEAR_EN    = 1'b1,
    parameter logic [31:0] CLEAR_VALUE = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_VALID,
    input  logic [4:0]  EX_ADDR,
    input  logic [31:0] EX_DATA,
    output logic        EX_READY,
    input  logic        MEM_VALID,
    input  logic [4:0]  MEM_ADDR,
    input  logic [31:0] MEM_DATA,
    output logic        MEM_READY,
    output logic [4:0]  DIR_WR,
    output logic [31:0] DI,
    output logic        REG_WR,
    output logic        CLR_DONE,
    output logic        CONFLICT
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam state_t RST_STATE = CLEAR_EN ? S_CLEAR : S_RUN;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Priority pointer: 0 = EX wins a tie, 1 = MEM wins a tie.
    logic        ptr_q, ptr_d;
    logic        reg_wr_q, reg_wr_d;
    logic [4:0]  dir_wr_q, dir_wr_d;
    logic [31:0] di_q, di_d;
    logic        conflict_q, conflict_d;
    logic        clr_done_q, clr_done_d;
    logic        ex_gnt, mem_gnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RST_STATE;
            cnt_q      <= 5'd1;
            ptr_q      <= 1'b0;
            reg_wr_q   <= 1'b0;
            dir_wr_q   <= 5'd0;
            di_q       <= 32'd0;
            conflict_q <= 1'b0;
            clr_done_q <= ~CLEAR_EN;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            reg_wr_q   <= reg_wr_d;
            dir_wr_q   <= dir_wr_d;
            di_q       <= di_d;
            conflict_q <= conflict_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        reg_wr_d   = 1'b0;
        dir_wr_d   = dir_wr_q;
        di_d       = di_q;
        conflict_d = 1'b0;
        clr_done_d = clr_done_q;
        ex_gnt     = 1'b0;
        mem_gnt    = 1'b0;

        case (state_q)
            S_CLEAR: begin
                reg_wr_d = 1'b1;
                dir_wr_d = cnt_q;
                di_d     = CLEAR_VALUE;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d    = S_RUN;
                    clr_done_d = 1'b1;
                end
            end
            S_RUN: begin
                conflict_d = EX_VALID & MEM_VALID;
                // A lone requester always wins; a tie goes to the pointer.
                ex_gnt  = EX_VALID  & (~MEM_VALID | ~ptr_q);
                mem_gnt = MEM_VALID & (~EX_VALID  |  ptr_q);
                if (ex_gnt) begin
                    ptr_d = 1'b1;
                    if (EX_ADDR != 5'd0) begin
                        reg_wr_d = 1'b1;
                        dir_wr_d = EX_ADDR;
                        di_d     = EX_DATA;
                    end
                end else if (mem_gnt) begin
                    ptr_d = 1'b0;
                    if (MEM_ADDR != 5'd0) begin
                        reg_wr_d = 1'b1;
                        dir_wr_d = MEM_ADDR;
                        di_d     = MEM_DATA;
                    end
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    assign EX_READY  = ex_gnt;
    assign MEM_READY = mem_gnt;
    assign DIR_WR    = dir_wr_q;
    assign DI        = di_q;
    assign REG_WR    = reg_wr_q;
    assign CLR_DONE  = clr_done_q;
    assign CONFLICT  = conflict_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
module tb_regbank_wr_arbiter;

    logic        clk;
    logic        rst_a, rst_b;
    logic        ex_valid, mem_valid;
    logic [4:0]  ex_addr, mem_addr;
    logic [31:0] ex_data, mem_data;

    logic        ex_ready_a, mem_ready_a, reg_wr_a, clr_done_a, conflict_a;
    logic [4:0]  dir_wr_a;
    logic [31:0] di_a;
    logic        ex_ready_b, mem_ready_b, reg_wr_b, clr_done_b, conflict_b;
    logic [4:0]  dir_wr_b;
    logic [31:0] di_b;

    logic [31:0] bank [32];

    int total;
    int passed;

    regbank_wr_arbiter #(.CLEAR_EN(1'b1), .CLEAR_VALUE(32'h0)) dut_a (
        .CLK(clk), .RST(rst_a),
        .EX_VALID(ex_valid), .EX_ADDR(ex_addr), .EX_DATA(ex_data), .EX_READY(ex_ready_a),
        .MEM_VALID(mem_valid), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data), .MEM_READY(mem_ready_a),
        .DIR_WR(dir_wr_a), .DI(di_a), .REG_WR(reg_wr_a), .CLR_DONE(clr_done_a), .CONFLICT(conflict_a)
    );

    regbank_wr_arbiter #(.CLEAR_EN(1'b0), .CLEAR_VALUE(32'h0)) dut_b (
        .CLK(clk), .RST(rst_b),
        .EX_VALID(ex_valid), .EX_ADDR(ex_addr), .EX_DATA(ex_data), .EX_READY(ex_ready_b),
        .MEM_VALID(mem_valid), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data), .MEM_READY(mem_ready_b),
        .DIR_WR(dir_wr_b), .DI(di_b), .REG_WR(reg_wr_b), .CLR_DONE(clr_done_b), .CONFLICT(conflict_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: x0 is not hardwired so any stray x0 write shows up.
    always @(posedge clk) begin
        if (reg_wr_a) bank[dir_wr_a] <= di_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset_clear();
        total++; if (reg_wr_a !== 1'b0) $display("FAIL rst_reg_wr: got %0h want 0", reg_wr_a); else passed++;
        total++; if (dir_wr_a !== 5'd0) $display("FAIL rst_dir_wr: got %0h want 0", dir_wr_a); else passed++;
        total++; if (di_a !== 32'd0) $display("FAIL rst_di: got %0h want 0", di_a); else passed++;
        total++; if (clr_done_a !== 1'b0) $display("FAIL rst_clr_done: got %0h want 0", clr_done_a); else passed++;
        total++; if (conflict_a !== 1'b0) $display("FAIL rst_conflict: got %0h want 0", conflict_a); else passed++;
        // Hold an x0 request through the sweep to watch READY stay low.
        ex_valid = 1'b1; ex_addr = 5'd0; ex_data = 32'h1234;
        #1;
        total++; if (ex_ready_a !== 1'b0) $display("FAIL rst_ex_ready: got %0h want 0", ex_ready_a); else passed++;
        @(negedge clk) rst_a = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            total++; if (reg_wr_a !== 1'b1) $display("FAIL clr_reg_wr k=%0d: got %0h want 1", k, reg_wr_a); else passed++;
            total++; if (dir_wr_a !== 5'(k)) $display("FAIL clr_dir_wr k=%0d: got %0d want %0d", k, dir_wr_a, k); else passed++;
            total++; if (di_a !== 32'd0) $display("FAIL clr_di k=%0d: got %0h want 0", k, di_a); else passed++;
            total++; if (clr_done_a !== (k == 31)) $display("FAIL clr_done k=%0d: got %0h want %0h", k, clr_done_a, (k == 31)); else passed++;
            total++; if (ex_ready_a !== (k == 31)) $display("FAIL clr_ex_ready k=%0d: got %0h want %0h", k, ex_ready_a, (k == 31)); else passed++;
        end
        ex_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (reg_wr_a !== 1'b0) $display("FAIL clr_end_reg_wr: got %0h want 0", reg_wr_a); else passed++;
        for (int r = 0; r < 32; r++) begin
            total++; if (bank[r] !== 32'd0) $display("FAIL clr_bank x%0d: got %0h want 0", r, bank[r]); else passed++;
        end
    endtask

    task automatic test_single();
        ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'd50;
        #1;
        total++; if (ex_ready_a !== 1'b1) $display("FAIL single_ex_ready: got %0h want 1", ex_ready_a); else passed++;
        total++; if (mem_ready_a !== 1'b0) $display("FAIL single_mem_ready: got %0h want 0", mem_ready_a); else passed++;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        total++; if (reg_wr_a !== 1'b1) $display("FAIL single_reg_wr: got %0h want 1", reg_wr_a); else passed++;
        total++; if (dir_wr_a !== 5'd5) $display("FAIL single_dir_wr: got %0d want 5", dir_wr_a); else passed++;
        total++; if (di_a !== 32'd50) $display("FAIL single_di: got %0d want 50", di_a); else passed++;
        total++; if (conflict_a !== 1'b0) $display("FAIL single_conflict: got %0h want 0", conflict_a); else passed++;
        @(posedge clk); #1;
        total++; if (reg_wr_a !== 1'b0) $display("FAIL single_idle_reg_wr: got %0h want 0", reg_wr_a); else passed++;
        total++; if (bank[5] !== 32'd50) $display("FAIL single_bank x5: got %0d want 50", bank[5]); else passed++;
    endtask

    task automatic test_x0_drop();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hDEAD;
        #1;
        total++; if (mem_ready_a !== 1'b1) $display("FAIL x0_mem_ready: got %0h want 1", mem_ready_a); else passed++;
        total++; if (ex_ready_a !== 1'b0) $display("FAIL x0_ex_ready: got %0h want 0", ex_ready_a); else passed++;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        total++; if (reg_wr_a !== 1'b0) $display("FAIL x0_reg_wr: got %0h want 0", reg_wr_a); else passed++;
        total++; if (dir_wr_a !== 5'd5) $display("FAIL x0_dir_hold: got %0d want 5", dir_wr_a); else passed++;
        total++; if (di_a !== 32'd50) $display("FAIL x0_di_hold: got %0h want 32", di_a); else passed++;
        @(posedge clk); #1;
        total++; if (bank[0] !== 32'd0) $display("FAIL x0_bank x0: got %0h want 0", bank[0]); else passed++;
    endtask

    task automatic test_round_robin();
        logic [4:0]  ex_a  [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
        logic [31:0] ex_d  [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
        logic [4:0]  mem_a [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
        logic [31:0] mem_d [4] = '{32'd110, 32'd120, 32'd130, 32'd140};
        // Expected commit order when both stay valid until drained.
        logic [4:0]  exp_a [8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        logic [31:0] exp_d [8] = '{32'd10, 32'd110, 32'd20, 32'd120, 32'd30, 32'd130, 32'd40, 32'd140};
        logic        exp_ex [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        exp_cf [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int ei = 0;
        int mi = 0;
        for (int c = 0; c < 8; c++) begin
            ex_valid  = (ei < 4); ex_addr  = ex_a[ei % 4];  ex_data  = ex_d[ei % 4];
            mem_valid = (mi < 4); mem_addr = mem_a[mi % 4]; mem_data = mem_d[mi % 4];
            #1;
            total++; if (ex_ready_a !== exp_ex[c]) $display("FAIL rr_ex_ready c=%0d: got %0h want %0h", c, ex_ready_a, exp_ex[c]); else passed++;
            total++; if (mem_ready_a !== !exp_ex[c]) $display("FAIL rr_mem_ready c=%0d: got %0h want %0h", c, mem_ready_a, !exp_ex[c]); else passed++;
            @(posedge clk); #1;
            if (exp_ex[c]) ei++; else mi++;
            total++; if (reg_wr_a !== 1'b1) $display("FAIL rr_reg_wr c=%0d: got %0h want 1", c, reg_wr_a); else passed++;
            total++; if (dir_wr_a !== exp_a[c]) $display("FAIL rr_dir_wr c=%0d: got %0d want %0d", c, dir_wr_a, exp_a[c]); else passed++;
            total++; if (di_a !== exp_d[c]) $display("FAIL rr_di c=%0d: got %0d want %0d", c, di_a, exp_d[c]); else passed++;
            total++; if (conflict_a !== exp_cf[c]) $display("FAIL rr_conflict c=%0d: got %0h want %0h", c, conflict_a, exp_cf[c]); else passed++;
        end
        ex_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (conflict_a !== 1'b0) $display("FAIL rr_conflict_end: got %0h want 0", conflict_a); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if (bank[exp_a[i]] !== exp_d[i]) $display("FAIL rr_bank x%0d: got %0d want %0d", exp_a[i], bank[exp_a[i]], exp_d[i]); else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'd70;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        total++; if (reg_wr_a !== 1'b1 || dir_wr_a !== 5'd7) $display("FAIL mid_accept: got wr=%0h dir=%0d want wr=1 dir=7", reg_wr_a, dir_wr_a); else passed++;
        rst_a = 1'b1;
        #1;
        total++; if (reg_wr_a !== 1'b0) $display("FAIL mid_reg_wr_drop: got %0h want 0", reg_wr_a); else passed++;
        total++; if (dir_wr_a !== 5'd0) $display("FAIL mid_dir_wr: got %0d want 0", dir_wr_a); else passed++;
        total++; if (di_a !== 32'd0) $display("FAIL mid_di: got %0h want 0", di_a); else passed++;
        total++; if (clr_done_a !== 1'b0) $display("FAIL mid_clr_done: got %0h want 0", clr_done_a); else passed++;
        @(posedge clk); #1;
        total++; if (bank[7] !== 32'd0) $display("FAIL mid_bank x7: got %0d want 0", bank[7]); else passed++;
        @(negedge clk) rst_a = 1'b0;
        @(posedge clk); #1;
        total++; if (reg_wr_a !== 1'b1) $display("FAIL mid_restart_wr: got %0h want 1", reg_wr_a); else passed++;
        total++; if (dir_wr_a !== 5'd1) $display("FAIL mid_restart_dir: got %0d want 1", dir_wr_a); else passed++;
        repeat (30) @(posedge clk);
        #1;
        total++; if (clr_done_a !== 1'b1 || dir_wr_a !== 5'd31) $display("FAIL mid_reclear_done: got done=%0h dir=%0d want done=1 dir=31", clr_done_a, dir_wr_a); else passed++;
    endtask

    task automatic test_clear_en_off();
        total++; if (clr_done_b !== 1'b1) $display("FAIL noclr_done_in_rst: got %0h want 1", clr_done_b); else passed++;
        total++; if (reg_wr_b !== 1'b0) $display("FAIL noclr_reg_wr_in_rst: got %0h want 0", reg_wr_b); else passed++;
        ex_valid = 1'b1; ex_addr = 5'd9; ex_data = 32'd99;
        @(negedge clk) rst_b = 1'b0;
        #1;
        total++; if (ex_ready_b !== 1'b1) $display("FAIL noclr_ex_ready: got %0h want 1", ex_ready_b); else passed++;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        total++; if (reg_wr_b !== 1'b1) $display("FAIL noclr_reg_wr: got %0h want 1", reg_wr_b); else passed++;
        total++; if (dir_wr_b !== 5'd9) $display("FAIL noclr_dir_wr: got %0d want 9", dir_wr_b); else passed++;
        total++; if (di_b !== 32'd99) $display("FAIL noclr_di: got %0d want 99", di_b); else passed++;
        total++; if (clr_done_b !== 1'b1) $display("FAIL noclr_done: got %0h want 1", clr_done_b); else passed++;
    endtask

    initial begin
        total = 0; passed = 0;
        bank[0] = 32'd0;
        for (int r = 1; r < 32; r++) bank[r] = 32'hFFFF_FFFF;
        rst_a = 1'b0; rst_b = 1'b0;
        ex_valid = 1'b0; ex_addr = 5'd0; ex_data = 32'd0;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset_clear();
        test_single();
        test_x0_drop();
        test_round_robin();
        test_reset_midstream();
        test_clear_en_off();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
